lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Load/store initiator sitting between the core's execute/memory stage and DataMem.
- Accepts one load/store request at a time over a valid/ready handshake and drives DataMem's MemRead/MemWrite/F3/addr/data_in ports.
- Returns load data or completion, plus a fault flag, as a single-cycle response pulse.
- Optionally splits misaligned halfword/word accesses into sequential byte accesses.

Parameters:
- ADDR_W, 10, memory byte-address width (matches DataMem addr).
- XLEN, 32, data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_f3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  XLEN  extended load data; 0 for stores and faults.
- rsp_fault  out  1  request rejected; qualified by rsp_valid.
- mem_read  out  1  to DataMem MemRead.
- mem_write  out  1  to DataMem MemWrite.
- mem_f3  out  3  to DataMem F3.
- mem_addr  out  ADDR_W  to DataMem addr.
- mem_wdata  out  XLEN  to DataMem data_in.
- mem_rdata  in  XLEN  from DataMem data_out; combinational read, already extended per mem_f3.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset: state IDLE. rsp_valid=0, rsp_rdata=0, rsp_fault=0, mem_read=0, mem_write=0, mem_f3=0, mem_addr=0, mem_wdata=0. req_ready=1, decoded combinationally from IDLE.
- DataMem contract: writes commit at the rising edge while mem_write=1; reads are valid in the same cycle as mem_addr.
- States: IDLE, ACCESS, SPLIT, RESP.
- IDLE:
  - req_ready=1; request is accepted when req_valid && req_ready at a rising edge; all req_* fields are latched.
  - Decode at acceptance:
    - Illegal f3 (011, 110, 111) or a store with f3 100/101 -> RESP with fault=1; no memory cycle.
    - Aligned -> ACCESS.
    - Misaligned (H/HU with addr[0]=1; W with addr[1:0]!=0) -> see Optional Feature.
- ACCESS: one cycle.
  - mem_f3=latched f3, mem_addr=latched addr, mem_wdata=latched wdata.
  - mem_read=~we, mem_write=we.
  - Load data is captured from mem_rdata at the end of the cycle; -> RESP.
- SPLIT: one byte per cycle, byte index i = 0..N-1 (N=2 for H/HU, 4 for W).
  - mem_addr = base+i, modulo 2^ADDR_W (wraps 0x3FF -> 0x000).
  - Store: mem_f3=000, mem_write=1, mem_wdata[7:0]=wdata byte i, upper bits 0.
  - Load: mem_f3=100, mem_read=1; mem_rdata[7:0] is stored into assembly byte i (little-endian).
  - After i=N-1 -> RESP.
  - Extension on assembly: H sign-extends from bit 15, HU zero-extends, W has none.
- RESP: one cycle.
  - rsp_valid=1; rsp_rdata/rsp_fault valid.
  - All mem_* strobes 0; req_ready=0.
  - Next state IDLE.
- req_ready is 0 in ACCESS/SPLIT/RESP. No back-to-back acceptance, so throughput is at most one request per 3 cycles aligned, or N+2 cycles split.
- Latency: accept at edge k -> rsp_valid high in cycle k+2 (aligned/fault k+1 for faults), k+N+1 for split.
  - Fault responses go directly IDLE -> RESP: rsp_valid in cycle k+1.
- mem_read and mem_write are never high together; both are 0 outside ACCESS/SPLIT.
- Reset mid-operation:
  - Immediate return to IDLE with all outputs at reset values; no response is issued.
  - Bytes of a split store already committed stay written.
- rsp_valid has no backpressure; the consumer must sample it.

Optional Feature:
- Macro LSU_MISALIGN_SPLIT_EN.
- Defined: misaligned H/HU/W accesses go through SPLIT as above; B/BU are never misaligned.
- Undefined: misaligned accesses go IDLE -> RESP with rsp_fault=1 and no memory strobe. The SPLIT state and assembly logic are not compiled.

Decomposition:
- Package lsu_pkg:
  - F3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum lsu_state_t {IDLE, ACCESS, SPLIT, RESP}.
  - Misalignment check function.
- Sub-module lsu_load_ext (combinational): assembled bytes plus f3 -> extended XLEN result. Used only under LSU_MISALIGN_SPLIT_EN.

Test Plan:
- SW: addr 0x000, wdata 0x88888889 -> one cycle mem_write=1, mem_f3=010. Then LW addr 0 -> rsp_rdata 0x88888889, fault 0, rsp_valid 2 cycles after accept.
- SB: 0x80 to addr 0x009, then LB addr 9 -> rsp_rdata 0xFFFFFF80; LBU addr 9 -> 0x00000080.
- Illegal f3 011 load, and store with f3 100 -> rsp_fault=1 one cycle after accept, rsp_rdata 0, mem_read/mem_write never asserted.
- With macro: SW 0x11223344 at addr 0x005 -> 4 SB cycles, addr 5,6,7,8, data 44,33,22,11. LW addr 5 -> 0x11223344. LH addr 0x007 -> 0x00001122; with byte 8 = 0x91, LH addr 7 -> 0xFFFF9122.
- With macro: SH 0xBEEF at addr 0x3FF -> bytes at 0x3FF then 0x000. Without macro: same request -> rsp_fault=1, no write.
- Assert rst_n low during SPLIT cycle 2 of a SW -> outputs 0 and req_ready 1 immediately. No rsp_valid follows; a new request is accepted after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants, FSM state type and access-decode helpers
// for the load/store initiator (lsu_mem_ctrl) and its load extender.
package lsu_pkg;

   // RISC-V funct3 encodings for loads/stores
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      SPLIT  = 2'd2,
      RESP   = 2'd3
   } lsu_state_t;

   // Halfwords need bit 0 clear, words need bits 1:0 clear; bytes are always aligned.
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lsb);
      logic mis;
      mis = 1'b0;
      case (f3)
         F3_H, F3_HU: mis = lsb[0];
         F3_W:        mis = (lsb != 2'b00);
         default:     mis = 1'b0;
      endcase
      return mis;
   endfunction

   // Unused funct3 codes are never legal; unsigned variants only exist for loads.
   function automatic logic is_illegal(input logic we, input logic [2:0] f3);
      logic ill;
      ill = 1'b0;
      case (f3)
         F3_B, F3_H, F3_W: ill = 1'b0;
         F3_BU, F3_HU:     ill = we;
         default:          ill = 1'b1;
      endcase
      return ill;
   endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// lsu_load_ext: sign/zero extension of a byte-assembled load value
// according to the load's funct3.
module lsu_load_ext
   import lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] asm_i,
   input  logic [2:0]      f3_i,
   output logic [XLEN-1:0] ext_o
);

   // Extend the assembled little-endian bytes to the full register width
   always_comb begin
      ext_o = asm_i;
      case (f3_i)
         F3_B:    ext_o = {{(XLEN-8){asm_i[7]}}, asm_i[7:0]};
         F3_BU:   ext_o = {{(XLEN-8){1'b0}}, asm_i[7:0]};
         F3_H:    ext_o = {{(XLEN-16){asm_i[15]}}, asm_i[15:0]};
         F3_HU:   ext_o = {{(XLEN-16){1'b0}}, asm_i[15:0]};
         default: ext_o = asm_i;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: single-outstanding load/store initiator driving DataMem.
// Optional macro LSU_MISALIGN_SPLIT_EN: when defined, misaligned H/HU/W
// accesses are split into sequential byte accesses; when undefined they
// are rejected with a fault response and no memory cycle.
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int XLEN   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_f3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              rsp_valid,
   output logic [XLEN-1:0]   rsp_rdata,
   output logic              rsp_fault,
   output logic              mem_read,
   output logic              mem_write,
   output logic [2:0]        mem_f3,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic [XLEN-1:0]   mem_rdata
);

   lsu_state_t        state_q, state_d;
   logic              we_q, we_d;
   logic [2:0]        f3_q, f3_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [XLEN-1:0]   rdata_q, rdata_d;
   logic              fault_q, fault_d;

`ifdef LSU_MISALIGN_SPLIT_EN
   logic [1:0]      idx_q, idx_d;
   logic [XLEN-1:0] asm_q, asm_d;
   logic [XLEN-1:0] asm_next;
   logic [XLEN-1:0] ext_res;
   logic [1:0]      last_idx;

   assign last_idx = (f3_q == F3_W) ? 2'd3 : 2'd1;

   // Merge the byte returned this cycle into the little-endian assembly
   always_comb begin
      asm_next = asm_q;
      asm_next[{idx_q, 3'b000} +: 8] = mem_rdata[7:0];
   end

   lsu_load_ext #(.XLEN(XLEN)) u_load_ext (
      .asm_i (asm_next),
      .f3_i  (f3_q),
      .ext_o (ext_res)
   );
`endif

   // State and latched request fields; reset returns to IDLE with nothing pending
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         f3_q    <= 3'b000;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         fault_q <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
         idx_q   <= 2'd0;
         asm_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         fault_q <= fault_d;
`ifdef LSU_MISALIGN_SPLIT_EN
         idx_q   <= idx_d;
         asm_q   <= asm_d;
`endif
      end
   end

   // Next-state decode and all outputs; memory strobes only in ACCESS/SPLIT
   always_comb begin
      state_d   = state_q;
      we_d      = we_q;
      f3_d      = f3_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      fault_d   = fault_q;
`ifdef LSU_MISALIGN_SPLIT_EN
      idx_d     = idx_q;
      asm_d     = asm_q;
`endif
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_rdata = '0;
      rsp_fault = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_f3    = 3'b000;
      mem_addr  = '0;
      mem_wdata = '0;

      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               we_d    = req_we;
               f3_d    = req_f3;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               rdata_d = '0;
               fault_d = 1'b0;
               if (is_illegal(req_we, req_f3)) begin
                  fault_d = 1'b1;
                  state_d = RESP;
               end else if (is_misaligned(req_f3, req_addr[1:0])) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                  idx_d   = 2'd0;
                  asm_d   = '0;
                  state_d = SPLIT;
`else
                  fault_d = 1'b1;
                  state_d = RESP;
`endif
               end else begin
                  state_d = ACCESS;
               end
            end
         end

         ACCESS: begin
            mem_read  = ~we_q;
            mem_write = we_q;
            mem_f3    = f3_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            rdata_d   = we_q ? '0 : mem_rdata;
            state_d   = RESP;
         end

`ifdef LSU_MISALIGN_SPLIT_EN
         SPLIT: begin
            mem_addr = addr_q + ADDR_W'(idx_q);
            if (we_q) begin
               mem_write      = 1'b1;
               mem_f3         = F3_B;
               mem_wdata[7:0] = wdata_q[{idx_q, 3'b000} +: 8];
            end else begin
               mem_read = 1'b1;
               mem_f3   = F3_BU;
               asm_d    = asm_next;
            end
            if (idx_q == last_idx) begin
               rdata_d = we_q ? '0 : ext_res;
               state_d = RESP;
            end else begin
               idx_d = idx_q + 2'd1;
            end
         end
`endif

         RESP: begin
            rsp_valid = 1'b1;
            rsp_rdata = rdata_q;
            rsp_fault = fault_q;
            state_d   = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed bench for lsu_mem_ctrl with a behavioural
// DataMem (combinational extended read, write at rising edge).
module tb_lsu_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_f3;
   logic [9:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;
   logic        mem_read;
   logic        mem_write;
   logic [2:0]  mem_f3;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   lsu_mem_ctrl #(.ADDR_W(10), .XLEN(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_f3    (req_f3),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_fault (rsp_fault),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_f3    (mem_f3),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   // ---------------- DataMem model ----------------
   logic [7:0]  mem [0:1023];
   bit          mem_init = 1'b0;
   logic [9:0]  a1, a2, a3;
   logic [9:0]  wr_addr_log [$];
   logic [31:0] wr_data_log [$];
   logic [2:0]  wr_f3_log   [$];
   int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, rsp_cnt = 0;

   assign a1 = mem_addr + 10'd1;
   assign a2 = mem_addr + 10'd2;
   assign a3 = mem_addr + 10'd3;

   always_comb begin
      mem_rdata = 32'h0;
      case (mem_f3)
         3'b000: mem_rdata = {{24{mem[mem_addr][7]}}, mem[mem_addr]};
         3'b100: mem_rdata = {24'h0, mem[mem_addr]};
         3'b001: mem_rdata = {{16{mem[a1][7]}}, mem[a1], mem[mem_addr]};
         3'b101: mem_rdata = {16'h0, mem[a1], mem[mem_addr]};
         3'b010: mem_rdata = {mem[a3], mem[a2], mem[a1], mem[mem_addr]};
         default: mem_rdata = 32'h0;
      endcase
   end

   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
         mem_init <= 1'b1;
      end else if (mem_write) begin
         mem[mem_addr] <= mem_wdata[7:0];
         if (mem_f3 == 3'b001 || mem_f3 == 3'b010) mem[a1] <= mem_wdata[15:8];
         if (mem_f3 == 3'b010) begin
            mem[a2] <= mem_wdata[23:16];
            mem[a3] <= mem_wdata[31:24];
         end
         wr_addr_log.push_back(mem_addr);
         wr_data_log.push_back(mem_wdata);
         wr_f3_log.push_back(mem_f3);
      end
      if (mem_read)  rd_cnt++;
      if (mem_write) wr_cnt++;
      if (mem_read && mem_write) both_cnt++;
      if (rsp_valid) rsp_cnt++;
   end

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_req(input logic we, input logic [2:0] f3, input logic [9:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd,
                         output logic flt, output int lat);
      @(negedge clk);
      wr_addr_log.delete();
      wr_data_log.delete();
      wr_f3_log.delete();
      req_valid = 1'b1;
      req_we    = we;
      req_f3    = f3;
      req_addr  = addr;
      req_wdata = wd;
      chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat = 0;
      rd  = 32'h0;
      flt = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (rsp_valid) begin
            lat = c;
            rd  = rsp_rdata;
            flt = rsp_fault;
            break;
         end
      end
      if (lat != 0)
         chk("resp_no_strobe", {29'h0, mem_read, mem_write, req_ready}, 32'h0);
   endtask

   logic [31:0] rd;
   logic        flt;
   int          lat;
   int          rd0, wr0, rsp0;

   initial begin
      rst_n = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_f3 = 3'b000;
      req_addr = 10'h0; req_wdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready",  {31'h0, req_ready}, 32'h1);
      chk("rst_flags",  {28'h0, rsp_valid, rsp_fault, mem_read, mem_write}, 32'h0);
      chk("rst_rdata",  rsp_rdata, 32'h0);
      chk("rst_maddr",  {22'h0, mem_addr}, 32'h0);
      chk("rst_mwdata", mem_wdata, 32'h0);
      chk("rst_mf3",    {29'h0, mem_f3}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Aligned SW then LW
      do_req(1'b1, 3'b010, 10'h000, 32'h88888889, rd, flt, lat);
      chk("sw_lat", 32'(lat), 32'd2);
      chk("sw_fault", {31'h0, flt}, 32'h0);
      chk("sw_wrcount", 32'(wr_addr_log.size()), 32'd1);
      chk("sw_wr_f3", {29'h0, wr_f3_log[0]}, 32'h2);
      chk("sw_wr_addr", {22'h0, wr_addr_log[0]}, 32'h0);
      chk("sw_wr_data", wr_data_log[0], 32'h88888889);
      do_req(1'b0, 3'b010, 10'h000, 32'h0, rd, flt, lat);
      chk("lw_lat", 32'(lat), 32'd2);
      chk("lw_data", rd, 32'h88888889);
      chk("lw_fault", {31'h0, flt}, 32'h0);

      // SB then LB / LBU
      do_req(1'b1, 3'b000, 10'h009, 32'h00000080, rd, flt, lat);
      chk("sb_lat", 32'(lat), 32'd2);
      do_req(1'b0, 3'b000, 10'h009, 32'h0, rd, flt, lat);
      chk("lb_data", rd, 32'hFFFFFF80);
      do_req(1'b0, 3'b100, 10'h009, 32'h0, rd, flt, lat);
      chk("lbu_data", rd, 32'h00000080);

      // Illegal requests fault after one cycle with no memory activity
      rd0 = rd_cnt; wr0 = wr_cnt;
      do_req(1'b0, 3'b011, 10'h000, 32'h0, rd, flt, lat);
      chk("ill_ld_lat", 32'(lat), 32'd1);
      chk("ill_ld_fault", {31'h0, flt}, 32'h1);
      chk("ill_ld_rdata", rd, 32'h0);
      do_req(1'b1, 3'b100, 10'h000, 32'hFFFFFFFF, rd, flt, lat);
      chk("ill_st_lat", 32'(lat), 32'd1);
      chk("ill_st_fault", {31'h0, flt}, 32'h1);
      chk("ill_st_rdata", rd, 32'h0);
      chk("ill_no_read", 32'(rd_cnt - rd0), 32'd0);
      chk("ill_no_write", 32'(wr_cnt - wr0), 32'd0);

`ifdef LSU_MISALIGN_SPLIT_EN
      // Misaligned word store split into four bytes
      do_req(1'b1, 3'b010, 10'h005, 32'h11223344, rd, flt, lat);
      chk("ssw_lat", 32'(lat), 32'd5);
      chk("ssw_fault", {31'h0, flt}, 32'h0);
      chk("ssw_count", 32'(wr_addr_log.size()), 32'd4);
      chk("ssw_a0", {22'h0, wr_addr_log[0]}, 32'h5);
      chk("ssw_a3", {22'h0, wr_addr_log[3]}, 32'h8);
      chk("ssw_d0", wr_data_log[0], 32'h44);
      chk("ssw_d1", wr_data_log[1], 32'h33);
      chk("ssw_d2", wr_data_log[2], 32'h22);
      chk("ssw_d3", wr_data_log[3], 32'h11);
      chk("ssw_f3", {29'h0, wr_f3_log[2]}, 32'h0);
      do_req(1'b0, 3'b010, 10'h005, 32'h0, rd, flt, lat);
      chk("slw_lat", 32'(lat), 32'd5);
      chk("slw_data", rd, 32'h11223344);
      do_req(1'b0, 3'b001, 10'h007, 32'h0, rd, flt, lat);
      chk("slh_lat", 32'(lat), 32'd3);
      chk("slh_pos", rd, 32'h00001122);
      do_req(1'b1, 3'b000, 10'h008, 32'h00000091, rd, flt, lat);
      do_req(1'b0, 3'b001, 10'h007, 32'h0, rd, flt, lat);
      chk("slh_neg", rd, 32'hFFFF9122);
      do_req(1'b0, 3'b101, 10'h007, 32'h0, rd, flt, lat);
      chk("slhu", rd, 32'h00009122);

      // Halfword store wrapping past the top of memory
      do_req(1'b1, 3'b001, 10'h3FF, 32'h0000BEEF, rd, flt, lat);
      chk("wrap_fault", {31'h0, flt}, 32'h0);
      chk("wrap_count", 32'(wr_addr_log.size()), 32'd2);
      chk("wrap_a0", {22'h0, wr_addr_log[0]}, 32'h3FF);
      chk("wrap_a1", {22'h0, wr_addr_log[1]}, 32'h000);
      chk("wrap_m3ff", {24'h0, mem[10'h3FF]}, 32'hEF);
      chk("wrap_m000", {24'h0, mem[10'h000]}, 32'hBE);

      // Reset during the second byte of a split word store
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_f3 = 3'b010;
      req_addr = 10'h011; req_wdata = 32'hAABBCCDD;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mid_addr_pre", {22'h0, mem_addr}, 32'h012);
      rsp0 = rsp_cnt;
      rst_n = 1'b0;
      #1;
      chk("mid_flags", {27'h0, rsp_valid, rsp_fault, mem_read, mem_write, req_ready}, 32'h1);
      chk("mid_maddr", {22'h0, mem_addr}, 32'h0);
      chk("mid_mwdata", mem_wdata, 32'h0);
      chk("mid_mf3", {29'h0, mem_f3}, 32'h0);
      chk("mid_rdata", rsp_rdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("mid_no_rsp", 32'(rsp_cnt - rsp0), 32'd0);
      chk("mid_byte0", {24'h0, mem[10'h011]}, 32'hDD);
      chk("mid_byte1", {24'h0, mem[10'h012]}, 32'h00);
      do_req(1'b0, 3'b100, 10'h011, 32'h0, rd, flt, lat);
      chk("mid_after_lat", 32'(lat), 32'd2);
      chk("mid_after_data", rd, 32'h000000DD);
`else
      // Misaligned requests fault without touching memory
      wr0 = wr_cnt; rd0 = rd_cnt;
      do_req(1'b1, 3'b001, 10'h3FF, 32'h0000BEEF, rd, flt, lat);
      chk("mis_sh_lat", 32'(lat), 32'd1);
      chk("mis_sh_fault", {31'h0, flt}, 32'h1);
      chk("mis_sh_nowrite", 32'(wr_cnt - wr0), 32'd0);
      chk("mis_sh_mem", {24'h0, mem[10'h3FF]}, 32'h0);
      do_req(1'b0, 3'b010, 10'h005, 32'h0, rd, flt, lat);
      chk("mis_lw_fault", {31'h0, flt}, 32'h1);
      chk("mis_lw_rdata", rd, 32'h0);
      chk("mis_noread", 32'(rd_cnt - rd0), 32'd0);

      // Reset during the access cycle of an aligned store
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_f3 = 3'b010;
      req_addr = 10'h010; req_wdata = 32'hAABBCCDD;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("mid_wr_pre", {31'h0, mem_write}, 32'h1);
      rsp0 = rsp_cnt;
      rst_n = 1'b0;
      #1;
      chk("mid_flags", {27'h0, rsp_valid, rsp_fault, mem_read, mem_write, req_ready}, 32'h1);
      chk("mid_maddr", {22'h0, mem_addr}, 32'h0);
      chk("mid_mwdata", mem_wdata, 32'h0);
      chk("mid_mf3", {29'h0, mem_f3}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("mid_no_rsp", 32'(rsp_cnt - rsp0), 32'd0);
      do_req(1'b0, 3'b010, 10'h010, 32'h0, rd, flt, lat);
      chk("mid_after_lat", 32'(lat), 32'd2);
      chk("mid_after_data", rd, 32'h0);
`endif

      chk("never_rd_wr", 32'(both_cnt), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
